bias_relu_sched: RTL and testbench

- Sequencer for the bias-add/ReLU post-processing datapath on the conv engine output path.
- For each of ChanNum output channels, fetches one bias word from bias RAM, then streams PixNum accumulator words into the datapath with the matching bias.
- Holds the datapath configuration (BiasEn, ReLUEn, ReLUMod, binary points) stable for a whole job.
- Uses valid/ready handshakes on both stream sides; one-entry registered output stage.

---
 rtl/bias_relu_sched_pkg.sv | 19 +
 rtl/bias_relu_ostage.sv | 55 +++++
 rtl/bias_relu_sched.sv | 185 ++++++++++++++++++
 tb/tb_bias_relu_sched.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_relu_sched_pkg.sv
// Shared types and default widths for the bias-add/ReLU sequencer.
// Imported by the top-level sequencer and by its output stage.
package bias_relu_sched_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CH_W_DEF   = 10;
  localparam int unsigned PIX_W_DEF  = 16;
  localparam int unsigned BP_W_DEF   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BREQ,
    ST_BWAIT,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/bias_relu_ostage.sv
// One-entry registered valid/ready output stage carrying a {data, bias} pair.
// Push and pop in the same cycle keep the stage full for 1 word/cycle.
module bias_relu_ostage
  import bias_relu_sched_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] bias_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [DATA_W-1:0] bias_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] bias_q;
  logic              valid_q;
  logic              valid_d;

  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (push_i) begin
      valid_d = 1'b1;
    end else if (ready_i && valid_q) begin
      valid_d = 1'b0;
    end
  end

  // Payload only changes on a push, so a stalled word stays stable.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q  <= '0;
      bias_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push_i && !flush_i) begin
        data_q <= data_i;
        bias_q <= bias_i;
      end
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign bias_o  = bias_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/bias_relu_sched.sv
// Bias-add/ReLU sequencer: per channel fetches one bias word, then streams
// PixNum accumulator words to the datapath paired with that bias.
module bias_relu_sched
  import bias_relu_sched_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CH_W   = CH_W_DEF,
  parameter int unsigned PIX_W  = PIX_W_DEF,
  parameter int unsigned BP_W   = BP_W_DEF
) (
  input  logic              Clk_i,
  input  logic              Rst_n_i,
  input  logic              Start_i,
  input  logic              Abort_i,
  input  logic [CH_W-1:0]   ChanNum_i,
  input  logic [PIX_W-1:0]  PixNum_i,
  input  logic [CH_W-1:0]   BiasBase_i,
  input  logic              CfgBiasEn_i,
  input  logic              CfgReLUEn_i,
  input  logic              CfgReLUMod_i,
  input  logic [BP_W-1:0]   CfgDataBp_i,
  input  logic [BP_W-1:0]   CfgWeightBp_i,
  input  logic [BP_W-1:0]   CfgResultBp_i,
  output logic              BiasRdEn_o,
  output logic [CH_W-1:0]   BiasAddr_o,
  input  logic [DATA_W-1:0] BiasRdData_i,
  input  logic [DATA_W-1:0] In_Data_i,
  input  logic              In_Valid_i,
  output logic              In_Ready_o,
  output logic [DATA_W-1:0] Dp_Data_o,
  output logic [DATA_W-1:0] Dp_Bias_o,
  output logic              Dp_Valid_o,
  input  logic              Dp_Ready_i,
  output logic              Dp_BiasEn_o,
  output logic              Dp_ReLUEn_o,
  output logic              Dp_ReLUMod_o,
  output logic [BP_W-1:0]   Dp_DataBp_o,
  output logic [BP_W-1:0]   Dp_WeightBp_o,
  output logic [BP_W-1:0]   Dp_ResultBp_o,
  output logic              Busy_o,
  output logic              Done_o
);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [CH_W-1:0]   chan_num_q;
  logic [PIX_W-1:0]  pix_num_q;
  logic [CH_W-1:0]   bias_base_q;
  logic [DATA_W-1:0] bias_q;
  logic              bias_en_q, relu_en_q, relu_mod_q;
  logic [BP_W-1:0]   data_bp_q, weight_bp_q, result_bp_q;

  logic start_acc;
  logic in_xfer;
  logic last_pix;
  logic last_ch;

  assign start_acc  = (state_q == ST_IDLE) && Start_i && !Abort_i;
  assign In_Ready_o = (state_q == ST_RUN) && (!Dp_Valid_o || Dp_Ready_i);
  assign in_xfer    = In_Valid_i && In_Ready_o;
  assign last_pix   = (pix_cnt_q == (pix_num_q - PIX_W'(1)));
  assign last_ch    = (ch_cnt_q == (chan_num_q - CH_W'(1)));

  always_comb begin
    state_d   = state_q;
    ch_cnt_d  = ch_cnt_q;
    pix_cnt_d = pix_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          ch_cnt_d  = '0;
          pix_cnt_d = '0;
          if ((ChanNum_i == '0) || (PixNum_i == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_BREQ;
          end
        end
      end
      ST_BREQ:  state_d = ST_BWAIT;
      ST_BWAIT: state_d = ST_RUN;
      ST_RUN: begin
        if (in_xfer) begin
          if (last_pix) begin
            pix_cnt_d = '0;
            if (last_ch) begin
              state_d = ST_DRAIN;
            end else begin
              ch_cnt_d = ch_cnt_q + CH_W'(1);
              state_d  = ST_BREQ;
            end
          end else begin
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
          end
        end
      end
      // Leave once the stage is empty or is being popped this cycle.
      ST_DRAIN: begin
        if (!Dp_Valid_o || Dp_Ready_i) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (Abort_i) begin
      state_d   = ST_IDLE;
      ch_cnt_d  = '0;
      pix_cnt_d = '0;
    end
  end

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      state_q   <= ST_IDLE;
      ch_cnt_q  <= '0;
      pix_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ch_cnt_q  <= ch_cnt_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  // Job configuration is captured only on an accepted start and survives abort.
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      chan_num_q  <= '0;
      pix_num_q   <= '0;
      bias_base_q <= '0;
      bias_en_q   <= 1'b0;
      relu_en_q   <= 1'b0;
      relu_mod_q  <= 1'b0;
      data_bp_q   <= '0;
      weight_bp_q <= '0;
      result_bp_q <= '0;
    end else if (start_acc) begin
      chan_num_q  <= ChanNum_i;
      pix_num_q   <= PixNum_i;
      bias_base_q <= BiasBase_i;
      bias_en_q   <= CfgBiasEn_i;
      relu_en_q   <= CfgReLUEn_i;
      relu_mod_q  <= CfgReLUMod_i;
      data_bp_q   <= CfgDataBp_i;
      weight_bp_q <= CfgWeightBp_i;
      result_bp_q <= CfgResultBp_i;
    end
  end

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      bias_q <= '0;
    end else if (state_q == ST_BWAIT) begin
      bias_q <= BiasRdData_i;
    end
  end

  bias_relu_ostage #(
    .DATA_W (DATA_W)
  ) u_ostage (
    .clk_i   (Clk_i),
    .rst_n_i (Rst_n_i),
    .flush_i (Abort_i),
    .push_i  (in_xfer),
    .data_i  (In_Data_i),
    .bias_i  (bias_q),
    .ready_i (Dp_Ready_i),
    .data_o  (Dp_Data_o),
    .bias_o  (Dp_Bias_o),
    .valid_o (Dp_Valid_o)
  );

  assign BiasRdEn_o    = (state_q == ST_BREQ);
  assign BiasAddr_o    = bias_base_q + ch_cnt_q;
  assign Busy_o        = (state_q != ST_IDLE);
  assign Done_o        = (state_q == ST_DONE);
  assign Dp_BiasEn_o   = bias_en_q;
  assign Dp_ReLUEn_o   = relu_en_q;
  assign Dp_ReLUMod_o  = relu_mod_q;
  assign Dp_DataBp_o   = data_bp_q;
  assign Dp_WeightBp_o = weight_bp_q;
  assign Dp_ResultBp_o = result_bp_q;

endmodule

// File: tb/tb_bias_relu_sched.sv
// Scoreboard bench for bias_relu_sched: stimulus pushes expected {data,bias}
// pairs, a negedge monitor pops and compares on every output transfer.
module tb_bias_relu_sched;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CH_W   = 10;
  localparam int unsigned PIX_W  = 16;
  localparam int unsigned BP_W   = 4;
  localparam logic [31:0] CFG_EXP = {17'd0, 1'b1, 1'b0, 1'b1, 4'h3, 4'h5, 4'hA};

  logic              Clk_i, Rst_n_i, Start_i, Abort_i;
  logic [CH_W-1:0]   ChanNum_i, BiasBase_i, BiasAddr_o;
  logic [PIX_W-1:0]  PixNum_i;
  logic              CfgBiasEn_i, CfgReLUEn_i, CfgReLUMod_i;
  logic [BP_W-1:0]   CfgDataBp_i, CfgWeightBp_i, CfgResultBp_i;
  logic              BiasRdEn_o;
  logic [DATA_W-1:0] BiasRdData_i, In_Data_i, Dp_Data_o, Dp_Bias_o;
  logic              In_Valid_i, In_Ready_o, Dp_Valid_o, Dp_Ready_i;
  logic              Dp_BiasEn_o, Dp_ReLUEn_o, Dp_ReLUMod_o;
  logic [BP_W-1:0]   Dp_DataBp_o, Dp_WeightBp_o, Dp_ResultBp_o;
  logic              Busy_o, Done_o;

  bias_relu_sched #(
    .DATA_W (DATA_W),
    .CH_W   (CH_W),
    .PIX_W  (PIX_W),
    .BP_W   (BP_W)
  ) dut (
    .Clk_i         (Clk_i),
    .Rst_n_i       (Rst_n_i),
    .Start_i       (Start_i),
    .Abort_i       (Abort_i),
    .ChanNum_i     (ChanNum_i),
    .PixNum_i      (PixNum_i),
    .BiasBase_i    (BiasBase_i),
    .CfgBiasEn_i   (CfgBiasEn_i),
    .CfgReLUEn_i   (CfgReLUEn_i),
    .CfgReLUMod_i  (CfgReLUMod_i),
    .CfgDataBp_i   (CfgDataBp_i),
    .CfgWeightBp_i (CfgWeightBp_i),
    .CfgResultBp_i (CfgResultBp_i),
    .BiasRdEn_o    (BiasRdEn_o),
    .BiasAddr_o    (BiasAddr_o),
    .BiasRdData_i  (BiasRdData_i),
    .In_Data_i     (In_Data_i),
    .In_Valid_i    (In_Valid_i),
    .In_Ready_o    (In_Ready_o),
    .Dp_Data_o     (Dp_Data_o),
    .Dp_Bias_o     (Dp_Bias_o),
    .Dp_Valid_o    (Dp_Valid_o),
    .Dp_Ready_i    (Dp_Ready_i),
    .Dp_BiasEn_o   (Dp_BiasEn_o),
    .Dp_ReLUEn_o   (Dp_ReLUEn_o),
    .Dp_ReLUMod_o  (Dp_ReLUMod_o),
    .Dp_DataBp_o   (Dp_DataBp_o),
    .Dp_WeightBp_o (Dp_WeightBp_o),
    .Dp_ResultBp_o (Dp_ResultBp_o),
    .Busy_o        (Busy_o),
    .Done_o        (Done_o)
  );

  initial Clk_i = 1'b0;
  always #5 Clk_i = ~Clk_i;

  // Bias RAM model: one-cycle registered read.
  logic [DATA_W-1:0] mem [0:1023];
  logic [DATA_W-1:0] rd_q;
  always @(posedge Clk_i) if (BiasRdEn_o) rd_q <= mem[BiasAddr_o];
  assign BiasRdData_i = rd_q;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] b;
  } pair_t;

  pair_t           sb_q[$];
  logic [CH_W-1:0] addr_q[$];
  int              n_checks = 0;
  int              n_errors = 0;
  int              done_cnt = 0;
  bit              tog_en   = 1'b0;
  bit              held_v   = 1'b0;
  bit              done_prev = 1'b0;
  logic [DATA_W-1:0] held_d, held_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cfg_out();
    return {17'd0, Dp_BiasEn_o, Dp_ReLUEn_o, Dp_ReLUMod_o,
            Dp_DataBp_o, Dp_WeightBp_o, Dp_ResultBp_o};
  endfunction

  // Monitor: output transfers, stall stability, Done/Busy relation, bias reads.
  always @(negedge Clk_i) begin
    pair_t e;
    if (!Rst_n_i) begin
      held_v    = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (done_prev) begin
        check("busy_after_done", {31'd0, Busy_o}, 32'd0);
        check("done_width", {31'd0, Done_o}, 32'd0);
      end
      done_prev = Done_o;
      if (Done_o) done_cnt++;
      if (BiasRdEn_o) addr_q.push_back(BiasAddr_o);
      if (held_v) begin
        check("stall_data", Dp_Data_o, held_d);
        check("stall_bias", Dp_Bias_o, held_b);
      end
      held_v = Dp_Valid_o && !Dp_Ready_i;
      held_d = Dp_Data_o;
      held_b = Dp_Bias_o;
      if (Dp_Valid_o && Dp_Ready_i) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_out: got data 0x%0h bias 0x%0h, expected no output",
                   Dp_Data_o, Dp_Bias_o);
        end else begin
          e = sb_q.pop_front();
          if (Dp_Data_o !== e.d || Dp_Bias_o !== e.b) begin
            n_errors++;
            $display("FAIL out_pair: got (0x%0h,0x%0h), expected (0x%0h,0x%0h)",
                     Dp_Data_o, Dp_Bias_o, e.d, e.b);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge Clk_i);
      #1;
      if (tog_en) Dp_Ready_i = ~Dp_Ready_i;
    end
  end

  task automatic tick();
    @(posedge Clk_i);
    #1;
  endtask

  task automatic start_job(input logic [CH_W-1:0] chan, input logic [PIX_W-1:0] pix,
                           input logic [CH_W-1:0] base);
    ChanNum_i  = chan;
    PixNum_i   = pix;
    BiasBase_i = base;
    Start_i    = 1'b1;
    tick();
    Start_i    = 1'b0;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] b);
    logic r;
    bit   ok;
    ok = 1'b0;
    sb_q.push_back('{d: d, b: b});
    In_Data_i  = d;
    In_Valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk_i);
      r = In_Ready_o;
      @(posedge Clk_i);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    In_Valid_i = 1'b0;
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL send_timeout: word 0x%0h not accepted in 50 cycles, expected acceptance", d);
    end
  endtask

  task automatic wait_done(input int maxc);
    int c0;
    c0 = done_cnt;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (done_cnt != c0) break;
    end
    tick();
    tick();
    check("done_pulses", done_cnt - c0, 32'd1);
    check("sb_empty", sb_q.size(), 32'd0);
  endtask

  task automatic check_addrs(input logic [CH_W-1:0] a0, input logic [CH_W-1:0] a1);
    check("addr_count", addr_q.size(), 32'd2);
    if (addr_q.size() >= 2) begin
      check("addr_first", {22'd0, addr_q[0]}, {22'd0, a0});
      check("addr_second", {22'd0, addr_q[1]}, {22'd0, a1});
    end
    addr_q.delete();
  endtask

  // Two channels of three pixels from base 5; optionally pokes Start mid-job.
  task automatic run_job_a(input bit poke_start);
    addr_q.delete();
    start_job(10'd2, 16'd3, 10'd5);
    check("busy_in_job", {31'd0, Busy_o}, 32'd1);
    for (int unsigned ch = 0; ch < 2; ch++) begin
      for (int unsigned p = 0; p < 3; p++) begin
        send_word(32'(ch * 3 + p + 1), (ch == 0) ? 32'h10 : 32'h20);
        if (poke_start && ch == 0 && p == 0) begin
          ChanNum_i     = 10'd1;
          PixNum_i      = 16'd1;
          BiasBase_i    = 10'd0;
          CfgBiasEn_i   = 1'b0;
          CfgDataBp_i   = 4'hF;
          Start_i       = 1'b1;
          tick();
          Start_i       = 1'b0;
        end
      end
    end
    wait_done(40);
    check_addrs(10'd5, 10'd6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int c0;
    int didx;
    Rst_n_i = 1'b0; Start_i = 1'b0; Abort_i = 1'b0;
    ChanNum_i = '0; PixNum_i = '0; BiasBase_i = '0;
    CfgBiasEn_i = 1'b0; CfgReLUEn_i = 1'b0; CfgReLUMod_i = 1'b0;
    CfgDataBp_i = '0; CfgWeightBp_i = '0; CfgResultBp_i = '0;
    In_Data_i = '0; In_Valid_i = 1'b0; Dp_Ready_i = 1'b0;
    foreach (mem[i]) mem[i] = '0;
    mem[5] = 32'h10; mem[6] = 32'h20; mem[10'h3FF] = 32'hAA; mem[0] = 32'hBB;

    repeat (3) @(posedge Clk_i);
    #1;
    check("rst_busy", {31'd0, Busy_o}, 32'd0);
    check("rst_done", {31'd0, Done_o}, 32'd0);
    check("rst_rden", {31'd0, BiasRdEn_o}, 32'd0);
    check("rst_addr", {22'd0, BiasAddr_o}, 32'd0);
    check("rst_in_ready", {31'd0, In_Ready_o}, 32'd0);
    check("rst_dp_valid", {31'd0, Dp_Valid_o}, 32'd0);
    check("rst_dp_data", Dp_Data_o, 32'd0);
    check("rst_dp_bias", Dp_Bias_o, 32'd0);
    check("rst_cfg", cfg_out(), 32'd0);
    Rst_n_i = 1'b1;
    tick();

    CfgBiasEn_i = 1'b1; CfgReLUEn_i = 1'b0; CfgReLUMod_i = 1'b1;
    CfgDataBp_i = 4'h3; CfgWeightBp_i = 4'h5; CfgResultBp_i = 4'hA;
    Dp_Ready_i = 1'b1;

    // Basic job, full throughput downstream.
    run_job_a(1'b0);
    check("cfg_latched", cfg_out(), CFG_EXP);
    CfgBiasEn_i = 1'b0; CfgResultBp_i = 4'h1;
    tick();
    check("cfg_hold_idle", cfg_out(), CFG_EXP);
    CfgBiasEn_i = 1'b1; CfgResultBp_i = 4'hA;

    // Same job with downstream ready toggling.
    tog_en = 1'b1;
    run_job_a(1'b0);
    tog_en = 1'b0;
    tick();
    tick();
    Dp_Ready_i = 1'b1;

    // Empty job: straight to DONE, no bias read, no input accepted.
    addr_q.delete();
    c0 = done_cnt;
    didx = -1;
    In_Valid_i = 1'b1;
    In_Data_i  = 32'hDEAD;
    start_job(10'd0, 16'd3, 10'd5);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk_i);
      check("zc_in_ready", {31'd0, In_Ready_o}, 32'd0);
      if (Done_o && didx < 0) didx = i;
      @(posedge Clk_i);
      #1;
    end
    In_Valid_i = 1'b0;
    check("zc_done_cycle", didx, 32'd0);
    check("zc_done_pulses", done_cnt - c0, 32'd1);
    check("zc_no_bias_rd", addr_q.size(), 32'd0);

    // Bias address wraps past the top of the RAM.
    addr_q.delete();
    start_job(10'd2, 16'd1, 10'h3FF);
    send_word(32'h77, 32'hAA);
    send_word(32'h88, 32'hBB);
    wait_done(40);
    check_addrs(10'h3FF, 10'h000);

    // Abort after two words, then a clean restart that ignores a mid-job Start.
    addr_q.delete();
    start_job(10'd2, 16'd3, 10'd5);
    send_word(32'd1, 32'h10);
    send_word(32'd2, 32'h10);
    c0 = done_cnt;
    Abort_i = 1'b1;
    tick();
    Abort_i = 1'b0;
    check("abort_busy", {31'd0, Busy_o}, 32'd0);
    check("abort_dp_valid", {31'd0, Dp_Valid_o}, 32'd0);
    tick();
    tick();
    check("abort_no_done", done_cnt - c0, 32'd0);
    check("abort_cfg_kept", cfg_out(), CFG_EXP);
    check("abort_sb_empty", sb_q.size(), 32'd0);
    run_job_a(1'b1);
    check("cfg_after_ignored_start", cfg_out(), CFG_EXP);
    CfgBiasEn_i = 1'b1;
    CfgDataBp_i = 4'h3;

    // Asynchronous reset in the middle of RUN with a stalled word held.
    start_job(10'd2, 16'd3, 10'd5);
    Dp_Ready_i = 1'b0;
    send_word(32'h55, 32'h10);
    #2;
    Rst_n_i = 1'b0;
    #1;
    check("arst_busy", {31'd0, Busy_o}, 32'd0);
    check("arst_dp_valid", {31'd0, Dp_Valid_o}, 32'd0);
    check("arst_dp_data", Dp_Data_o, 32'd0);
    check("arst_dp_bias", Dp_Bias_o, 32'd0);
    check("arst_in_ready", {31'd0, In_Ready_o}, 32'd0);
    check("arst_cfg", cfg_out(), 32'd0);
    sb_q.delete();
    tick();
    Rst_n_i = 1'b1;
    Dp_Ready_i = 1'b1;
    tick();
    run_job_a(1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
